// File: rtl/ysyx_23060124_wbu_commit_if.sv
// Bundle between the EXU/WBU pipeline register and the write-back stage,
// plus the write-back outputs towards the regfile, CSR file and IFU.
// The master side is the upstream/consumer environment; the slave side is the WBU.
interface ysyx_23060124_wbu_commit_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_pc_next;
  logic [31:0] i_res;
  logic [31:0] i_csr_wdata;
  logic [31:0] i_mepc;
  logic [31:0] i_mtvec;
  logic [4:0]  i_rd_addr;
  logic [11:0] i_csr_addr;
  logic        i_wen;
  logic        i_csr_wen;
  logic        i_brch;
  logic        i_jal;
  logic        i_jalr;
  logic        i_mret;
  logic        i_ecall;
  logic        i_ebreak;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_csr_wen;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_csr_wdata;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_commit;
  logic        o_halt;

  modport master (
    output i_valid, i_pc, i_pc_next, i_res, i_csr_wdata, i_mepc, i_mtvec,
           i_rd_addr, i_csr_addr, i_wen, i_csr_wen, i_brch, i_jal, i_jalr,
           i_mret, i_ecall, i_ebreak,
    input  o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_csr_wen, o_csr_waddr,
           o_csr_wdata, o_redirect, o_redirect_pc, o_commit, o_halt
  );

  modport slave (
    input  i_valid, i_pc, i_pc_next, i_res, i_csr_wdata, i_mepc, i_mtvec,
           i_rd_addr, i_csr_addr, i_wen, i_csr_wen, i_brch, i_jal, i_jalr,
           i_mret, i_ecall, i_ebreak,
    output o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_csr_wen, o_csr_waddr,
           o_csr_wdata, o_redirect, o_redirect_pc, o_commit, o_halt
  );
endinterface

// File: rtl/ysyx_23060124_wbu_commit.sv
// Write-back / commit stage.
// Drives the GPR write port, the single-port CSR write port, IFU redirect and
// the sticky ebreak halt. Ecall trap entry is split over two cycles (mepc, then
// mcause + redirect to mtvec) because the CSR file has only one write port.
// Optional retire counter: define YSYX_23060124_WBU_PERF_EN to add o_retire_cnt.
//
// state | meaning
// IDLE  | accepting bundles
// TRAP2 | second ecall cycle pending: mcause write + redirect to mtvec
// HALT  | ebreak retired, frozen until reset
module ysyx_23060124_wbu_commit #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11,
  parameter logic [11:0] CSR_MEPC     = 12'h341,
  parameter logic [11:0] CSR_MCAUSE   = 12'h342
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_23060124_wbu_commit_if.slave    bus
`ifdef YSYX_23060124_WBU_PERF_EN
  ,
  output logic [63:0]                  o_retire_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, TRAP2, HALT} state_e;

  state_e      state_q, state_d;
  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        csr_wen_q, csr_wen_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        commit_q, commit_d;
  logic        halt_q, halt_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        accept;

  assign bus.o_ready = (state_q == IDLE);
  assign accept      = bus.i_valid && bus.o_ready;

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    rf_wen_d      = 1'b0;
    rf_waddr_d    = 5'd0;
    rf_wdata_d    = 32'd0;
    csr_wen_d     = 1'b0;
    csr_waddr_d   = 12'd0;
    csr_wdata_d   = 32'd0;
    redirect_d    = 1'b0;
    redirect_pc_d = 32'd0;
    commit_d      = 1'b0;
    halt_d        = halt_q;
    mtvec_d       = mtvec_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rf_wen_d   = bus.i_wen && (bus.i_rd_addr != 5'd0);
          rf_waddr_d = bus.i_rd_addr;
          rf_wdata_d = bus.i_res;
          if (bus.i_ecall) begin
            // mepc now; mtvec is captured for the redirect issued next cycle
            csr_wen_d   = 1'b1;
            csr_waddr_d = CSR_MEPC;
            csr_wdata_d = bus.i_pc;
            mtvec_d     = bus.i_mtvec;
            state_d     = TRAP2;
          end else begin
            csr_wen_d   = bus.i_csr_wen;
            csr_waddr_d = bus.i_csr_addr;
            csr_wdata_d = bus.i_csr_wdata;
            commit_d    = 1'b1;
            if (bus.i_mret) begin
              redirect_d    = 1'b1;
              redirect_pc_d = bus.i_mepc;
            end else if (bus.i_jal || bus.i_jalr || (bus.i_brch && bus.i_res[0])) begin
              redirect_d    = 1'b1;
              redirect_pc_d = bus.i_pc_next;
            end
            if (bus.i_ebreak) begin
              halt_d  = 1'b1;
              state_d = HALT;
            end
          end
        end
      end
      TRAP2: begin
        csr_wen_d     = 1'b1;
        csr_waddr_d   = CSR_MCAUSE;
        csr_wdata_d   = MCAUSE_ECALL;
        redirect_d    = 1'b1;
        redirect_pc_d = mtvec_q;
        commit_d      = 1'b1;
        state_d       = IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= 32'd0;
      csr_wen_q     <= 1'b0;
      csr_waddr_q   <= 12'd0;
      csr_wdata_q   <= 32'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      commit_q      <= 1'b0;
      halt_q        <= 1'b0;
      mtvec_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      csr_wen_q     <= csr_wen_d;
      csr_waddr_q   <= csr_waddr_d;
      csr_wdata_q   <= csr_wdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      commit_q      <= commit_d;
      halt_q        <= halt_d;
      mtvec_q       <= mtvec_d;
    end
  end

  assign bus.o_rf_wen      = rf_wen_q;
  assign bus.o_rf_waddr    = rf_waddr_q;
  assign bus.o_rf_wdata    = rf_wdata_q;
  assign bus.o_csr_wen     = csr_wen_q;
  assign bus.o_csr_waddr   = csr_waddr_q;
  assign bus.o_csr_wdata   = csr_wdata_q;
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirect_pc = redirect_pc_q;
  assign bus.o_commit      = commit_q;
  assign bus.o_halt        = halt_q;

`ifdef YSYX_23060124_WBU_PERF_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Count retired instructions; natural 64-bit wrap.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit_q) retire_cnt_d = retire_cnt_q + 64'd1;
  end

  // Retire counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retire_cnt_q <= 64'd0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign o_retire_cnt = retire_cnt_q;
`endif

endmodule
